// File: rtl/leaf_stream_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : leaf_stream_buffer_pkg
// Description : Shared constants for the leaf user-side stream buffer:
//               default payload width and FIFO depth, plus the leaf packet
//               field widths used by the surrounding leaf interface.
// Revision    : 1.0 - initial release
// ============================================================================
package leaf_stream_buffer_pkg;

    // Payload width of the leaf user stream.
    localparam int DEF_DATA_BITS  = 32;

    // Leaf packet layout: payload plus routing fields.
    localparam int PACKET_BITS    = 49;
    localparam int NUM_LEAF_BITS  = 4;
    localparam int NUM_PORT_BITS  = 4;
    localparam int NUM_ADDR_BITS  = 7;

    // Elastic buffer depth is 2**DEF_DEPTH_BITS entries.
    localparam int DEF_DEPTH_BITS = 7;

endpackage : leaf_stream_buffer_pkg
`default_nettype wire

// File: rtl/leaf_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : leaf_sync_fifo
// Description : First-word-fall-through synchronous FIFO, 2**DEPTH_BITS deep.
//               The head entry is held in an output register so o_dout is
//               valid in the same cycle o_empty falls.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset (pointers, level, head)
//               i_push  - write i_din (ignored while full)
//               i_pop   - consume head entry (ignored while empty)
//               i_din   - write data
//               o_dout  - head entry
//               o_full  - occupancy equals depth
//               o_empty - occupancy is zero
//               o_level - occupancy, 0 .. 2**DEPTH_BITS
// Revision    : 1.0 - initial release
// ============================================================================
module leaf_sync_fifo
    import leaf_stream_buffer_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int DEPTH_BITS = DEF_DEPTH_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_BITS-1:0]  i_din,
    output logic [DATA_BITS-1:0]  o_dout,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_BITS:0]   o_level
);

    localparam logic [DEPTH_BITS:0]   c_LVL_ZERO = '0;
    localparam logic [DEPTH_BITS:0]   c_LVL_ONE  = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS:0]   c_LVL_FULL = (DEPTH_BITS+1)'(1 << DEPTH_BITS);
    localparam logic [DEPTH_BITS-1:0] c_PTR_ONE  = DEPTH_BITS'(1);

    logic [DATA_BITS-1:0]  r_mem [0:(1<<DEPTH_BITS)-1];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_level;
    logic [DATA_BITS-1:0]  r_dout;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr;
    logic                  w_rd;
    logic [DEPTH_BITS-1:0] w_rd_next;

    // Full/empty come from the occupancy count; pointer equality alone
    // cannot tell the two apart.
    assign w_full    = (r_level == c_LVL_FULL);
    assign w_empty   = (r_level == c_LVL_ZERO);
    assign w_wr      = i_push & ~w_full;
    assign w_rd      = i_pop  & ~w_empty;
    assign w_rd_next = r_rd_ptr + c_PTR_ONE;

    // Storage has no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= w_rd_next;
            end

            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase

            // Head register: the next entry moves up on a pop; with a single
            // entry left the only successor is the word being written now,
            // which is not yet readable from storage, so bypass it.
            if (w_rd) begin
                if (r_level == c_LVL_ONE) begin
                    if (w_wr) begin
                        r_dout <= i_din;
                    end
                end else begin
                    r_dout <= r_mem[w_rd_next];
                end
            end else if (w_empty && w_wr) begin
                r_dout <= i_din;
            end
        end
    end

    assign o_dout  = r_dout;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule : leaf_sync_fifo
`default_nettype wire

// File: rtl/leaf_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : leaf_stream_buffer
// Description : Elastic buffer and frame monitor between the leaf user output
//               (vld/ack stream) and a kernel AXIS input. Counts words
//               delivered to the kernel and pulses frame_done once every
//               FRAME_WORDS words.
// Ports       : clk        - clock, rising edge
//               reset      - synchronous active-high reset
//               clear      - synchronous flush of FIFO and counters
//               din/vld_in/ack_out  - upstream stream from the leaf
//               dout/vld_out/ack_in - downstream AXIS (TDATA/TVALID/TREADY)
//               level      - FIFO occupancy
//               word_cnt   - words delivered in the current frame
//               frame_cnt  - completed frames (wrapping)
//               frame_done - one-cycle pulse per completed frame
// Revision    : 1.0 - initial release
// ============================================================================
module leaf_stream_buffer
    import leaf_stream_buffer_pkg::*;
#(
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int DEPTH_BITS  = DEF_DEPTH_BITS,
    parameter int FRAME_WORDS = 1024,
    parameter int CNT_BITS    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DATA_BITS-1:0]  din,
    input  logic                  vld_in,
    output logic                  ack_out,
    output logic [DATA_BITS-1:0]  dout,
    output logic                  vld_out,
    input  logic                  ack_in,
    output logic [DEPTH_BITS:0]   level,
    output logic [CNT_BITS-1:0]   word_cnt,
    output logic [CNT_BITS-1:0]   frame_cnt,
    output logic                  frame_done
);

    localparam logic [CNT_BITS-1:0] c_LAST_WORD = CNT_BITS'(FRAME_WORDS - 1);
    localparam logic [CNT_BITS-1:0] c_CNT_ONE   = CNT_BITS'(1);

    logic                  w_flush;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_BITS-1:0]   r_word_cnt;
    logic [CNT_BITS-1:0]   r_frame_cnt;
    logic                  r_frame_done;

    // clear and reset have the same effect; either one drops any transfer
    // that coincides with it.
    assign w_flush = reset | clear;

    assign ack_out = ~w_full;
    assign vld_out = ~w_empty;
    assign w_push  = vld_in & ~w_full;
    assign w_pop   = ack_in & ~w_empty;

    leaf_sync_fifo #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (w_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (din),
        .o_dout  (dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_word_cnt   <= '0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_pop) begin
                if (r_word_cnt == c_LAST_WORD) begin
                    r_word_cnt   <= '0;
                    r_frame_cnt  <= r_frame_cnt + c_CNT_ONE;
                    r_frame_done <= 1'b1;
                end else begin
                    r_word_cnt   <= r_word_cnt + c_CNT_ONE;
                end
            end
        end
    end

    assign word_cnt   = r_word_cnt;
    assign frame_cnt  = r_frame_cnt;
    assign frame_done = r_frame_done;

endmodule : leaf_stream_buffer
`default_nettype wire

// File: tb/tb_leaf_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_leaf_stream_buffer
// Description : Directed self-checking bench for leaf_stream_buffer. A
//               FRAME_WORDS=4 instance carries the main checks; a
//               FRAME_WORDS=1 instance shares the same stimulus to exercise
//               back-to-back frame_done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_stream_buffer;

    localparam int DW  = 32;
    localparam int DB  = 7;
    localparam int CB  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic [DW-1:0] din;
    logic          vld_in;
    logic          ack_in;

    logic          ack_out,  vld_out,  frame_done;
    logic [DW-1:0] dout;
    logic [DB:0]   level;
    logic [CB-1:0] word_cnt, frame_cnt;

    logic          ack_out1, vld_out1, frame_done1;
    logic [DW-1:0] dout1;
    logic [DB:0]   level1;
    logic [CB-1:0] word_cnt1, frame_cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    leaf_stream_buffer #(
        .DATA_BITS(DW), .DEPTH_BITS(DB), .FRAME_WORDS(4), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .din(din), .vld_in(vld_in), .ack_out(ack_out),
        .dout(dout), .vld_out(vld_out), .ack_in(ack_in),
        .level(level), .word_cnt(word_cnt), .frame_cnt(frame_cnt),
        .frame_done(frame_done)
    );

    leaf_stream_buffer #(
        .DATA_BITS(DW), .DEPTH_BITS(DB), .FRAME_WORDS(1), .CNT_BITS(CB)
    ) dut1 (
        .clk(clk), .reset(reset), .clear(clear),
        .din(din), .vld_in(vld_in), .ack_out(ack_out1),
        .dout(dout1), .vld_out(vld_out1), .ack_in(ack_in),
        .level(level1), .word_cnt(word_cnt1), .frame_cnt(frame_cnt1),
        .frame_done(frame_done1)
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; vld_in = 1'b0; ack_in = 1'b0;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; vld_in = 1'b0; ack_in = 1'b0; din = '0;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (ack_out !== 1'b1) begin errors++; $display("FAIL reset_ack_out: got %0b want 1", ack_out); end
        checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld_out: got %0b want 0", vld_out); end
        checks++; if (level !== 8'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (dout !== 32'd0) begin errors++; $display("FAIL reset_dout: got %0h want 0", dout); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
    endtask

    task automatic test_fwft();
        din = 32'hA5A5_0001; vld_in = 1'b1; ack_in = 1'b0;
        step();
        vld_in = 1'b0; din = 32'h0;
        checks++; if (vld_out !== 1'b1) begin errors++; $display("FAIL fwft_vld: got %0b want 1", vld_out); end
        checks++; if (dout !== 32'hA5A5_0001) begin errors++; $display("FAIL fwft_dout: got %0h want a5a50001", dout); end
        checks++; if (level !== 8'd1) begin errors++; $display("FAIL fwft_level: got %0d want 1", level); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (dout !== 32'hA5A5_0001 || vld_out !== 1'b1) begin
                errors++; $display("FAIL fwft_hold[%0d]: got dout=%0h vld=%0b want a5a50001/1", i, dout, vld_out);
            end
        end
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL fwft_pop_vld: got %0b want 0", vld_out); end
        checks++; if (level !== 8'd0) begin errors++; $display("FAIL fwft_pop_level: got %0d want 0", level); end
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL fwft_word_cnt: got %0d want 1", word_cnt); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL fwft_frame_done: got %0b want 0", frame_done); end
    endtask

    task automatic test_full();
        do_clear();
        ack_in = 1'b0;
        for (int i = 0; i < 128; i++) begin
            din = i; vld_in = 1'b1;
            step();
        end
        checks++; if (level !== 8'd128) begin errors++; $display("FAIL full_level: got %0d want 128", level); end
        checks++; if (ack_out !== 1'b0) begin errors++; $display("FAIL full_ack_out: got %0b want 0", ack_out); end
        din = 32'hDEAD;
        step();
        checks++; if (level !== 8'd128) begin errors++; $display("FAIL full_reject_level: got %0d want 128", level); end
        checks++; if (dout !== 32'd0) begin errors++; $display("FAIL full_head: got %0h want 0", dout); end
        // Pop with vld_in still high: the full FIFO must not take 0xDEAD.
        ack_in = 1'b1;
        step();
        vld_in = 1'b0;
        checks++; if (level !== 8'd127) begin errors++; $display("FAIL full_pop_level: got %0d want 127", level); end
        checks++; if (ack_out !== 1'b1) begin errors++; $display("FAIL full_pop_ack_out: got %0b want 1", ack_out); end
        for (int i = 1; i < 128; i++) begin
            checks++;
            if (dout !== 32'(i) || vld_out !== 1'b1) begin
                errors++; $display("FAIL full_drain[%0d]: got dout=%0h vld=%0b want %0h/1", i, dout, vld_out, i);
            end
            step();
        end
        ack_in = 1'b0;
        checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL full_drain_empty: got vld=%0b dout=%0h want 0", vld_out, dout); end
        checks++; if (frame_cnt !== 16'd32) begin errors++; $display("FAIL full_frame_cnt: got %0d want 32", frame_cnt); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL full_word_cnt: got %0d want 0", word_cnt); end
    endtask

    task automatic test_frames();
        int pulses = 0;
        do_clear();
        din = 32'd100; vld_in = 1'b1; ack_in = 1'b0;
        step();
        ack_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            din = 32'd101 + 32'(k);
            checks++;
            if (dout !== 32'd100 + 32'(k) || dout1 !== 32'd100 + 32'(k)) begin
                errors++; $display("FAIL frame_order[%0d]: got %0h/%0h want %0h", k, dout, dout1, 100 + k);
            end
            step();
            if (frame_done === 1'b1) pulses++;
            checks++;
            if (frame_done !== (((k + 1) % 4) == 0)) begin
                errors++; $display("FAIL frame_done[%0d]: got %0b want %0b", k, frame_done, ((k + 1) % 4) == 0);
            end
            checks++;
            if (frame_done1 !== 1'b1) begin
                errors++; $display("FAIL frame_done_fw1[%0d]: got %0b want 1", k, frame_done1);
            end
            checks++;
            if (level !== 8'd1 || level1 !== 8'd1 || vld_out1 !== 1'b1 || ack_out1 !== 1'b1) begin
                errors++; $display("FAIL frame_level[%0d]: got %0d/%0d vld1=%0b ack1=%0b want 1/1/1/1", k, level, level1, vld_out1, ack_out1);
            end
        end
        vld_in = 1'b0; ack_in = 1'b0;
        checks++; if (pulses !== 3) begin errors++; $display("FAIL frame_pulses: got %0d want 3", pulses); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL frame_cnt: got %0d want 3", frame_cnt); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL frame_word_cnt: got %0d want 0", word_cnt); end
        checks++; if (frame_cnt1 !== 16'd12 || word_cnt1 !== 16'd0) begin errors++; $display("FAIL frame_cnt_fw1: got %0d/%0d want 12/0", frame_cnt1, word_cnt1); end
        step();
        checks++; if (frame_done !== 1'b0 || frame_done1 !== 1'b0) begin errors++; $display("FAIL frame_done_idle: got %0b/%0b want 0/0", frame_done, frame_done1); end
    endtask

    task automatic test_back_to_back();
        do_clear();
        ack_in = 1'b0; vld_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 32'd200 + 32'(i);
            step();
        end
        ack_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = 32'd205 + 32'(k);
            checks++;
            if (dout !== 32'd200 + 32'(k)) begin
                errors++; $display("FAIL b2b_order[%0d]: got %0h want %0h", k, dout, 200 + k);
            end
            step();
            checks++;
            if (level !== 8'd5) begin
                errors++; $display("FAIL b2b_level[%0d]: got %0d want 5", k, level);
            end
        end
        vld_in = 1'b0; ack_in = 1'b0;
        checks++; if (dout !== 32'd220) begin errors++; $display("FAIL b2b_head: got %0h want %0h", dout, 220); end
    endtask

    task automatic test_clear();
        do_clear();
        ack_in = 1'b0; vld_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            din = 32'd300 + 32'(i);
            step();
        end
        checks++; if (level !== 8'd50) begin errors++; $display("FAIL clear_prefill: got %0d want 50", level); end
        din = 32'd999; vld_in = 1'b1; ack_in = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0; vld_in = 1'b0; ack_in = 1'b0;
        checks++; if (level !== 8'd0) begin errors++; $display("FAIL clear_level: got %0d want 0", level); end
        checks++; if (vld_out !== 1'b0 || ack_out !== 1'b1) begin errors++; $display("FAIL clear_hs: got vld=%0b ack=%0b want 0/1", vld_out, ack_out); end
        checks++; if (word_cnt !== 16'd0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL clear_counts: got %0d/%0d want 0/0", word_cnt, frame_cnt); end
        checks++; if (frame_done1 !== 1'b0 || frame_cnt1 !== 16'd0) begin errors++; $display("FAIL clear_fw1: got done=%0b cnt=%0d want 0/0", frame_done1, frame_cnt1); end
        step();
        checks++; if (frame_done1 !== 1'b0 || level !== 8'd0) begin errors++; $display("FAIL clear_after: got done=%0b level=%0d want 0/0", frame_done1, level); end
    endtask

    initial begin
        test_reset();
        test_fwft();
        test_full();
        test_frames();
        test_back_to_back();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_leaf_stream_buffer
`default_nettype wire

// File: doc/leaf_stream_buffer.md
Name: leaf_stream_buffer

Overview:
- Elastic buffer plus frame monitor on the user side of a leaf.
- Sits between the leaf interface's user output (32-bit vld/ack stream) and the downstream kernel's AXIS input (TDATA/TVALID/TREADY).
- Absorbs network jitter with a first-word-fall-through FIFO.
- Counts words delivered to the kernel and pulses a frame-done flag every FRAME_WORDS words, so the controller can sequence ap_start per frame.

Parameters:
- DATA_BITS, 32, payload width (matches leaf payload).
- DEPTH_BITS, 7, FIFO depth is 2^DEPTH_BITS = 128 entries.
- FRAME_WORDS, 1024, words per frame; legal range 1 .. 2^CNT_BITS.
- CNT_BITS, 16, width of word-in-frame and frame counters.

Ports:
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high reset
- clear  input  1  synchronous flush of FIFO and counters
- din  input  DATA_BITS  data from leaf interface
- vld_in  input  1  din valid
- ack_out  output  1  ready to the leaf interface
- dout  output  DATA_BITS  data to kernel (Input_*_V_TDATA)
- vld_out  output  1  dout valid (TVALID)
- ack_in  input  1  kernel ready (TREADY)
- level  output  DEPTH_BITS+1  current occupancy, 0..2^DEPTH_BITS
- word_cnt  output  CNT_BITS  words delivered in the current frame
- frame_cnt  output  CNT_BITS  completed frames, wraps modulo 2^CNT_BITS
- frame_done  output  1  one-cycle pulse per completed frame

Behaviour:
- Handshakes follow AXIS semantics: a transfer occurs on a rising edge where valid and ready are both high.
  - Push = vld_in & ack_out; pop = vld_out & ack_in.
- ack_out = !full (combinational from registered level).
  - When full there is no write, even if a pop occurs in the same cycle.
  - ack_out reasserts the cycle after a pop.
- vld_out = !empty.
  - dout shows the head entry (first-word-fall-through) and is held stable while vld_out & !ack_in.
- Latency: a word pushed into an empty FIFO at edge N is visible on dout/vld_out after edge N; first pop possible at edge N+1.
- Simultaneous push and pop when neither full nor empty: level unchanged, both pointers advance.
- Pointers are DEPTH_BITS wide and wrap modulo 2^DEPTH_BITS. Full/empty are derived from level, never from pointer equality alone.
- Frame counting, on each pop:
  - If word_cnt == FRAME_WORDS-1: word_cnt <= 0, frame_cnt <= frame_cnt+1 (wrapping), frame_done <= 1 for exactly the next cycle.
  - Otherwise word_cnt <= word_cnt+1.
  - frame_done is registered and is 0 in all other cycles.
- FRAME_WORDS = 1: every pop pulses frame_done.
  - Back-to-back pops give frame_done high on consecutive cycles; each is a distinct pulse, one per frame.
- Reset (and clear, identical effect) clears level, pointers, word_cnt, frame_cnt and frame_done to 0.
  - Outputs after reset: ack_out = 1, vld_out = 0, dout = 0, level = 0.
  - FIFO storage contents need not be cleared.
- Reset/clear mid-operation overrides any push/pop in the same cycle: the data is dropped and nothing is counted.
- clear has the same priority as reset; reset dominates if both are asserted.
- No state machine beyond the counters. The FIFO storage may infer BRAM or LUTRAM, but the FWFT output register must keep dout valid the same cycle vld_out rises.

Decomposition:
- Shared package holds:
  - DATA_BITS default, 32;
  - leaf packet constants (PACKET_BITS 49, NUM_LEAF_BITS 4, NUM_PORT_BITS 4, NUM_ADDR_BITS 7);
  - DEPTH_BITS default, 7.
- One sub-module, leaf_sync_fifo: parameterised FWFT synchronous FIFO with push, pop, full, empty and level.
- leaf_stream_buffer contains the handshake glue and the frame counters.

Test Plan:
- Reset then idle -> ack_out=1, vld_out=0, level=0, word_cnt=0, frame_cnt=0, frame_done=0.
- Push 0xA5A50001 into empty FIFO with ack_in=0 -> next cycle vld_out=1, dout=0xA5A50001, level=1; hold 10 cycles, dout stable; raise ack_in -> popped, vld_out=0, word_cnt=1.
- Push 128 words (0..127) with ack_in=0 -> level=128, ack_out=0; push attempt of 0xDEAD is rejected; one pop -> dout sequence resumes at 0, ack_out=1 next cycle, 0xDEAD never appears.
- FRAME_WORDS=4, continuous push and pop of 12 words -> frame_done pulses exactly 3 times (after words 4, 8, 12), frame_cnt=3, word_cnt=0, level constant.
- Simultaneous push/pop at level=5 for 20 cycles -> level stays 5, output order is strict FIFO.
- Assert clear at level=50 while vld_in=ack_in=1 -> next cycle level=0, vld_out=0, counters=0, and neither the pushed nor the popped word is counted.
